// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and constants for the binary32 add/subtract unit
package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        ADD    = 3'd3,
        NORM   = 3'd4,
        ROUND  = 3'd5,
        DONE   = 3'd6
    } fpu_state_t;

    // Bit positions inside fpflags = {nv, of, uf, nx}
    typedef enum logic [1:0] {
        FLAG_NX = 2'd0,
        FLAG_UF = 2'd1,
        FLAG_OF = 2'd2,
        FLAG_NV = 2'd3
    } fpu_flag_idx_t;

    // Operand classification captured in the first UNPACK cycle
    typedef struct packed {
        logic a_zero;
        logic a_inf;
        logic a_nan;
        logic b_zero;
        logic b_inf;
        logic b_nan;
        logic a_ge;
    } fpu_cls_t;

    localparam logic [31:0] QNAN32   = 32'h7FC00000;
    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam int          DP_W     = 28;

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational 28-bit leading-zero counter
module fp_lzc
    import fpu_pkg::*;
(
    input  logic [DP_W-1:0] din,
    output logic [4:0]      cnt,
    output logic            zero
);

    // Scan upward so the highest set bit determines the count last
    always_comb begin
        cnt = 5'(DP_W);
        for (int i = 0; i < DP_W; i++) begin
            if (din[i]) begin
                cnt = 5'(DP_W - 1 - i);
            end
        end
    end

    assign zero = ~|din;

endmodule

// File: rtl/fpu_addsub_seq.sv
// rtl/fpu_addsub_seq.sv - multicycle binary32 add/subtract FSM
module fpu_addsub_seq
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic [3:0]  fpflags,
    output logic        busy,
    output logic        done
);

    localparam int SH_MAX = MAN_W + 4;
    localparam logic signed [9:0] EXP_MAX_S = 10'(EXP_MAX);

    fpu_state_t        state_q, state_d;
    logic              ph_q, ph_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    fpu_cls_t          cls_q, cls_d;
    logic              sign_q, sign_d, eff_sub_q, eff_sub_d;
    logic signed [9:0] exp_q, exp_d;
    logic [26:0]       big_q, big_d, small_q, small_d, mant_q, mant_d;
    logic [4:0]        shift_q, shift_d;
    logic [27:0]       sum_q, sum_d;
    logic [31:0]       res_q, res_d;
    logic [3:0]        flags_q, flags_d;

    logic [4:0]        lz;
    logic              lz_zero;

    // Working temporaries for the combinational step
    logic [EXP_W-1:0]  ea, eb, e_big, e_small, e_diff;
    logic [MAN_W-1:0]  ma, mb, m_big, m_small;
    logic [53:0]       wide;
    logic [23:0]       m_rnd;
    logic [24:0]       m_sum;
    logic              g, r, s, rup;
    logic signed [9:0] exp_r;
    logic [22:0]       man_out;

    fp_lzc u_lzc (
        .din  (sum_q),
        .cnt  (lz),
        .zero (lz_zero)
    );

    assign ea = a_q[MAN_W +: EXP_W];
    assign eb = b_q[MAN_W +: EXP_W];
    assign ma = a_q[MAN_W-1:0];
    assign mb = b_q[MAN_W-1:0];

    // Next-state and datapath step for the current FSM state
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        a_d       = a_q;
        b_d       = b_q;
        cls_d     = cls_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        exp_d     = exp_q;
        big_d     = big_q;
        small_d   = small_q;
        shift_d   = shift_q;
        sum_d     = sum_q;
        mant_d    = mant_q;
        res_d     = res_q;
        flags_d   = flags_q;
        e_big     = ea;
        e_small   = eb;
        m_big     = ma;
        m_small   = mb;
        e_diff    = '0;
        wide      = '0;
        m_rnd     = mant_q[26:3];
        g         = mant_q[2];
        r         = mant_q[1];
        s         = mant_q[0];
        rup       = 1'b0;
        m_sum     = '0;
        exp_r     = exp_q;
        man_out   = '0;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    // B is stored with its effective sign so subtraction is just addition
                    a_d     = a;
                    b_d     = {b[31] ^ sub, b[30:0]};
                    ph_d    = 1'b0;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                if (!ph_q) begin
                    // First cycle registers the classification, keeping the compare/swap off the latch path
                    cls_d.a_zero = (ea == '0);
                    cls_d.a_inf  = (&ea) && (ma == '0);
                    cls_d.a_nan  = (&ea) && (ma != '0);
                    cls_d.b_zero = (eb == '0);
                    cls_d.b_inf  = (&eb) && (mb == '0);
                    cls_d.b_nan  = (&eb) && (mb != '0);
                    cls_d.a_ge   = (a_q[30:0] >= b_q[30:0]);
                    ph_d         = 1'b1;
                end else begin
                    state_d = DONE;
                    flags_d = '0;
                    if (cls_q.a_nan || cls_q.b_nan ||
                        (cls_q.a_inf && cls_q.b_inf && (a_q[31] != b_q[31]))) begin
                        res_d            = QNAN32;
                        flags_d[FLAG_NV] = 1'b1;
                    end else if (cls_q.a_inf) begin
                        res_d = {a_q[31], 31'h7F800000};
                    end else if (cls_q.b_inf) begin
                        res_d = {b_q[31], 31'h7F800000};
                    end else if (cls_q.a_zero && cls_q.b_zero) begin
                        res_d = {a_q[31] & b_q[31], 31'b0};
                    end else if (cls_q.a_zero) begin
                        res_d = b_q;
                    end else if (cls_q.b_zero) begin
                        res_d = a_q;
                    end else begin
                        if (!cls_q.a_ge) begin
                            e_big   = eb;
                            e_small = ea;
                            m_big   = mb;
                            m_small = ma;
                        end
                        e_diff    = e_big - e_small;
                        sign_d    = cls_q.a_ge ? a_q[31] : b_q[31];
                        eff_sub_d = a_q[31] ^ b_q[31];
                        exp_d     = $signed({2'b00, e_big});
                        big_d     = {1'b1, m_big, 3'b000};
                        small_d   = {1'b1, m_small, 3'b000};
                        shift_d   = (e_diff > EXP_W'(SH_MAX)) ? 5'(SH_MAX) : e_diff[4:0];
                        state_d   = ALIGN;
                    end
                end
            end
            ALIGN: begin
                // Bits pushed below the datapath collapse into the sticky position
                wide    = {small_q, 27'b0} >> shift_q;
                small_d = {wide[53:28], wide[27] | (|wide[26:0])};
                state_d = ADD;
            end
            ADD: begin
                sum_d   = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                    : ({1'b0, big_q} + {1'b0, small_q});
                state_d = NORM;
            end
            NORM: begin
                if (lz_zero) begin
                    res_d   = '0;
                    flags_d = '0;
                    state_d = DONE;
                end else if (sum_q[27]) begin
                    mant_d  = {sum_q[27:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + 10'sd1;
                    state_d = ROUND;
                end else begin
                    // lz counts from bit 27, so a leading one at bit 26 needs no shift
                    mant_d  = sum_q[26:0] << (lz - 5'd1);
                    exp_d   = exp_q - $signed({5'b0, lz}) + 10'sd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                rup     = g & (r | s | m_rnd[0]);
                m_sum   = {1'b0, m_rnd} + {24'b0, rup};
                man_out = m_sum[22:0];
                if (m_sum[24]) begin
                    exp_r   = exp_q + 10'sd1;
                    man_out = m_sum[23:1];
                end
                flags_d = '0;
                if (exp_r >= EXP_MAX_S) begin
                    res_d            = {sign_q, 31'h7F800000};
                    flags_d[FLAG_OF] = 1'b1;
                    flags_d[FLAG_NX] = 1'b1;
                end else if (exp_r <= 10'sd0) begin
                    res_d            = {sign_q, 31'b0};
                    flags_d[FLAG_UF] = 1'b1;
                    flags_d[FLAG_NX] = 1'b1;
                end else begin
                    res_d            = {sign_q, exp_r[7:0], man_out};
                    flags_d[FLAG_NX] = g | r | s;
                end
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ph_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cls_q     <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            exp_q     <= '0;
            big_q     <= '0;
            small_q   <= '0;
            shift_q   <= '0;
            sum_q     <= '0;
            mant_q    <= '0;
            res_q     <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cls_q     <= cls_d;
            sign_q    <= sign_d;
            eff_sub_q <= eff_sub_d;
            exp_q     <= exp_d;
            big_q     <= big_d;
            small_q   <= small_d;
            shift_q   <= shift_d;
            sum_q     <= sum_d;
            mant_q    <= mant_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
        end
    end

    assign result  = res_q;
    assign fpflags = flags_q;
    assign done    = (state_q == DONE);
    assign busy    = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb/tb_fpu_addsub_seq.sv - scoreboard bench for fpu_addsub_seq
module tb_fpu_addsub_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic [3:0]  fpflags;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    fpu_addsub_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .result  (result),
        .fpflags (fpflags),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", result, e.r);
                check("fpflags", {28'b0, fpflags}, {28'b0, e.f});
                check("latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Drive one request at a negedge; edge k is the next posedge
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                         input logic [31:0] er, input logic [3:0] ef, input int lat);
        exp_t e;
        a = ta;
        b = tb_;
        sub = ts;
        start = 1'b1;
        e.r = er;
        e.f = ef;
        e.due = cyc + 1 + lat;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_result", result, 32'h0);
        check("rst_flags", {28'b0, fpflags}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 6); wait_idle();
        issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 5); wait_idle();
        issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 6); wait_idle();
        issue(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001, 6); wait_idle();
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 6); wait_idle();
        issue(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 6); wait_idle();
        issue(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 2); wait_idle();
        issue(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2); wait_idle();
        issue(32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 4'b0000, 2); wait_idle();
        issue(32'h00000000, 32'hC0000000, 1'b1, 32'h40000000, 4'b0000, 2); wait_idle();
        issue(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, 2); wait_idle();
        issue(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 2); wait_idle();

        // start while in ALIGN must be ignored
        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 6);
        @(negedge clk);
        @(negedge clk);
        a = 32'h40400000;
        b = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // start during the DONE cycle is accepted back-to-back
        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 6);
        repeat (6) @(negedge clk);
        check("done_seen_b2b", {31'b0, done}, 32'd1);
        issue(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 6);
        wait_idle();

        // asynchronous reset during ADD aborts silently
        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 6);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        sb_q.delete();
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_result", result, 32'h0);
        check("abort_flags", {28'b0, fpflags}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 6); wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_addsub_seq.md
Name: fpu_addsub_seq

Overview:
- Multicycle IEEE-754 binary32 add/subtract unit that produces the single-precision value written back through the FPU register file write port (FResult path).
- Sits upstream of the FPU register file.
- The controller pulses start, waits for done, then asserts FpuWrite with result on the write-data lane.
- The unit is sequential, with a fixed-latency pipeline-free FSM: one operation in flight at a time.

Parameters:
- EXP_W, 8, exponent field width (only the default is verified)
- MAN_W, 23, stored mantissa width (only the default is verified)

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  reset is asynchronous and active-low
- start  input  1  one-cycle request; operands sampled with it
- sub  input  1  1 = a - b, 0 = a + b
- a  input  32  operand A (binary32)
- b  input  32  operand B (binary32)
- result  output  32  packed binary32 result; valid while done=1 and held until the next accepted start
- fpflags  output  4  {nv, of, uf, nx}; same validity as result
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, result=0, fpflags=0, busy=0, done=0. All internal operand/mantissa registers are cleared.
- Reset mid-operation aborts the operation silently: no done pulse, and the old result is lost (reads 0).
- FSM states: IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE.
- Start acceptance: start is accepted only in IDLE or DONE, which allows back-to-back operations. In any other state start is ignored, with no queuing.
- On acceptance at edge k: a, b, and sub are latched. Effective sign of B = b[31]^sub. Next state is UNPACK; busy=1 from the cycle after edge k.
- UNPACK:
  - Flush-to-zero: exponent 0 is treated as ±0, whatever the mantissa.
  - Special cases go directly to DONE:
    - Any NaN input: result=0x7FC00000, nv=1.
    - Inf op Inf with opposite effective signs: result=0x7FC00000, nv=1.
    - Exactly one Inf, or two same-sign Infs: that Inf.
    - Both zero: result=+0, unless both effective signs are negative, then -0.
    - Exactly one operand zero: the other operand, exact.
  - Otherwise: implicit 1 is prepended, operands are swapped so |A|>=|B|, and the exponent difference d is computed.
- ALIGN: the smaller significand is shifted right by min(d, MAN_W+4) into a 27-bit datapath with guard, round and sticky bits. Sticky = OR of all bits shifted out.
- ADD: add or subtract the magnitudes per the effective signs. The result sign is the sign of the larger operand. A 28-bit sum holds the carry-out.
- NORM (single cycle; uses the fp_lzc sub-module):
  - Carry-out: shift right 1 with sticky folded in; exponent+1.
  - Else shift left by the leading-zero count; exponent−lzc.
  - Exact zero sum: result = +0, routed to DONE with nx=0.
- ROUND:
  - Round-to-nearest-even on guard/round/sticky. nx = any of G/R/S nonzero.
  - A rounding carry renormalizes, with exponent+1.
  - Exponent ≥ 255 gives ±Inf, of=1, nx=1.
  - Exponent ≤ 0 gives ±0, uf=1, nx=1 (flush to zero).
- DONE: done=1 for exactly this one cycle, busy=0, result/fpflags updated. Then IDLE, unless a new start is accepted.
- Latency:
  - Normal operands: done is high in the cycle starting at edge k+6.
  - Special/zero operands: done at edge k+2.
  - Exact-zero sum: done at edge k+5.
- result and fpflags change only on the transition into DONE. Between operations the last result is held.

Decomposition:
- fpu_pkg holds:
  - the FSM state enum (fpu_state_t);
  - constants QNAN32=32'h7FC00000, EXP_BIAS=127, EXP_MAX=255, DP_W=28;
  - a flag index typedef for {nv, of, uf, nx}.
- One sub-module, fp_lzc: a combinational 28-bit leading-zero counter with a 5-bit count output and an all-zero indicator. It is instantiated in NORM.
- All remaining logic lives in fpu_addsub_seq.

Test Plan:
- Basic add, with sub=0: a=0x3F800000, b=0x40000000 → result=0x40400000, fpflags=0, done exactly 6 cycles after start.
- Cancellation, with sub=1: a=b=0x3F800000 → result=0x00000000, fpflags=0.
- Rounding ties and overflow:
  - 0x3F800000+0x33800000 → 0x3F800000, nx=1 (tie to even).
  - 0x3F800000+0x33800001 → 0x3F800001, nx=1.
  - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, of=1, nx=1.
- Specials:
  - 0x7F800000−0x7F800000 → 0x7FC00000, nv=1, done 2 cycles after start.
  - 0x7FC00001+1.0 → 0x7FC00000, nv=1.
  - 0x00000001 (denormal) + 0x80000000 → 0x00000000.
- Handshake:
  - start while busy (in ALIGN) is ignored, and the first result is unaffected.
  - start in the DONE cycle is accepted, and a second correct result arrives 6 cycles later.
- Reset abort: reset=0 during ADD → busy=0, done=0, result=0 immediately (asynchronous). After release, start 1.0+1.0 → 0x40000000.
